eu_exp2: RTL and testbench

EU_EXP2 -- requirements
Module: eu_exp2

---
 rtl/eu_exp2_pkg.sv | 37 +++
 rtl/pwl_exp2_lut.sv | 20 ++
 rtl/eu_exp2.sv | 111 +++++++++++
 tb/tb_eu_exp2.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/eu_exp2_pkg.sv
// Shared constants for the exponent unit: Q formats, segment count,
// saturation value and the secant coefficients of the 2^f table.
package eu_exp2_pkg;

    localparam int EU_WIDTH        = 32;
    localparam int EU_Q_IN         = 22;
    localparam int EU_Q_OUT        = 16;
    localparam int EU_NUM_SEGMENTS = 8;
    localparam int EU_SEG_W        = $clog2(EU_NUM_SEGMENTS);
    localparam int EU_LUT_PORTS    = 32;

    localparam logic [63:0] EU_SAT = 64'h7FFF_FFFF_FFFF_FFFF;

    // K_i = 8*(2^((i+1)/8) - 2^(i/8)), B_i = 2^(i/8) - K_i*i/8, Q10.22
    localparam logic [31:0] EU_K [EU_NUM_SEGMENTS] = '{
        32'h002E_5708, 32'h0032_88BA, 32'h0037_1B99, 32'h003C_1872,
        32'h0041_88DB, 32'h0047_774B, 32'h004D_EF28, 32'h0054_FCE4
    };

    localparam logic [31:0] EU_B [EU_NUM_SEGMENTS] = '{
        32'h0040_0000, 32'h003F_79CA, 32'h003E_5512, 32'h003C_7641,
        32'h0039_BE0C, 32'h0036_0906, 32'h0031_2F20, 32'h002B_031C
    };

    typedef struct packed {
        logic [EU_WIDTH-1:0] k;
        logic [EU_WIDTH-1:0] b;
    } coef_t;

    function automatic coef_t eu_coef(input logic [EU_SEG_W-1:0] i);
        coef_t c;
        c.k = EU_K[i];
        c.b = EU_B[i];
        return c;
    endfunction

endpackage

// File: rtl/pwl_exp2_lut.sv
// Combinational multi-port coefficient table for 2^f, f in [0,1).
// Each port returns the secant slope K and intercept B of its segment.
module pwl_exp2_lut
    import eu_exp2_pkg::*;
#(
    parameter int NUM_PORTS = EU_LUT_PORTS
) (
    input  logic [NUM_PORTS*EU_SEG_W-1:0] seg_i,
    output logic [NUM_PORTS*EU_WIDTH-1:0] k_o,
    output logic [NUM_PORTS*EU_WIDTH-1:0] b_o
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        coef_t c;
        assign c = eu_coef(seg_i[p*EU_SEG_W +: EU_SEG_W]);
        assign k_o[p*EU_WIDTH +: EU_WIDTH] = c.k;
        assign b_o[p*EU_WIDTH +: EU_WIDTH] = c.b;
    end

endmodule

// File: rtl/eu_exp2.sv
// Two-stage pipelined 2^x: split + table lookup, then multiply-add
// and a saturating barrel shift into Q48.16.
module eu_exp2
    import eu_exp2_pkg::*;
#(
    parameter int WIDTH        = EU_WIDTH,
    parameter int Q_IN         = EU_Q_IN,
    parameter int Q_OUT        = EU_Q_OUT,
    parameter int NUM_SEGMENTS = EU_NUM_SEGMENTS
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [WIDTH-1:0]                s_x,
    output logic                            out_valid,
    output logic [$clog2(NUM_SEGMENTS)-1:0] segment_index,
    output logic [2*WIDTH-1:0]              exp_result
);

    localparam int SEG_W     = $clog2(NUM_SEGMENTS);
    localparam int IW        = WIDTH - Q_IN;
    localparam int RW        = 2 * WIDTH;
    localparam int SAT_SHIFT = RW - 1 - Q_IN;
    localparam logic [RW-1:0] SAT = RW'(EU_SAT);

    logic signed [IW-1:0] int_d;
    logic [Q_IN-1:0]      frac_d;
    logic [SEG_W-1:0]     seg_d;
    logic [WIDTH-1:0]     k_d;
    logic [WIDTH-1:0]     b_d;

    logic                 valid1_q;
    logic signed [IW-1:0] int_q;
    logic [Q_IN-1:0]      frac_q;
    logic [SEG_W-1:0]     seg1_q;
    logic [WIDTH-1:0]     k_q;
    logic [WIDTH-1:0]     b_q;

    logic                 valid2_q;
    logic [SEG_W-1:0]     seg2_q;
    logic [RW-1:0]        res_q;

    logic signed [RW-1:0] prod;
    logic signed [RW-1:0] mant;
    logic signed [31:0]   shift;
    logic [31:0]          rshift;
    logic [RW-1:0]        res_d;

    assign int_d  = s_x[WIDTH-1:Q_IN];
    assign frac_d = s_x[Q_IN-1:0];
    assign seg_d  = s_x[Q_IN-1 -: SEG_W];

    pwl_exp2_lut #(
        .NUM_PORTS(1)
    ) u_lut (
        .seg_i(seg_d),
        .k_o  (k_d),
        .b_o  (b_d)
    );

    always_comb begin
        prod   = RW'($signed(k_q)) * RW'($signed({1'b0, frac_q}));
        mant   = (prod >>> Q_IN) + RW'($signed(b_q));
        shift  = 32'(int_q) - 32'(Q_IN - Q_OUT);
        rshift = 32'(-shift);
        res_d  = '0;
        if (shift >= SAT_SHIFT) begin
            res_d = SAT;
        end else if (shift >= 0) begin
            // any bit landing on or above the sign bit saturates
            if ((mant >> (32'(RW - 1) - shift)) != '0) begin
                res_d = SAT;
            end else begin
                res_d = mant << shift;
            end
        end else if (rshift >= 32'(RW)) begin
            res_d = '0;
        end else begin
            res_d = mant >>> rshift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid1_q <= 1'b0;
            int_q    <= '0;
            frac_q   <= '0;
            seg1_q   <= '0;
            k_q      <= '0;
            b_q      <= '0;
            valid2_q <= 1'b0;
            seg2_q   <= '0;
            res_q    <= '0;
        end else begin
            valid1_q <= in_valid;
            int_q    <= int_d;
            frac_q   <= frac_d;
            seg1_q   <= seg_d;
            k_q      <= k_d;
            b_q      <= b_d;
            valid2_q <= valid1_q;
            seg2_q   <= seg1_q;
            res_q    <= res_d;
        end
    end

    assign out_valid     = valid2_q;
    assign segment_index = seg2_q;
    assign exp_result    = res_q;

endmodule

// File: tb/tb_eu_exp2.sv
// Bench for eu_exp2: directed table, random stream against a real-valued
// 2^x model, and a mid-stream reset sequence.
module tb_eu_exp2;

    localparam real ONE_Q22 = 4194304.0;
    localparam real TWO_63  = 9.223372036854775808e18;
    localparam logic [63:0] SAT = 64'h7FFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] s_x;
    logic        out_valid;
    logic [2:0]  segment_index;
    logic [63:0] exp_result;

    always #5 clk = ~clk;

    eu_exp2 dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .s_x          (s_x),
        .out_valid    (out_valid),
        .segment_index(segment_index),
        .exp_result   (exp_result)
    );

    typedef struct {
        logic [31:0] x;
        logic [63:0] exp;
        bit          exact;
        int          seg;
    } vec_t;

    typedef struct {
        bit   v;
        vec_t d;
    } cyc_t;

    vec_t tbl[19];
    cyc_t stim[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic real xval(input logic [31:0] x);
        return $itor($signed(x)) / ONE_Q22;
    endfunction

    function automatic int seg_ref(input logic [31:0] x);
        real r;
        r = xval(x);
        return int'($floor((r - $floor(r)) * 8.0));
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic check_out(input string tag, input vec_t d);
        int  seg;
        real r;
        real a;
        real tol;
        nvec++;
        if (out_valid !== 1'b1) begin
            nerr++;
            $display("FAIL %s out_valid: got %b want 1", tag, out_valid);
            return;
        end
        seg = (d.seg >= 0) ? d.seg : seg_ref(d.x);
        chk({tag, " seg"}, 64'(segment_index), 64'(seg));
        if (d.exact) begin
            chk({tag, " value"}, exp_result, d.exp);
        end else begin
            r = $pow(2.0, xval(d.x)) * 65536.0;
            if (r >= TWO_63) begin
                chk({tag, " sat"}, exp_result, SAT);
            end else begin
                nvec++;
                a   = exp_result;
                tol = r * 0.003 + 2.0;
                if (exp_result[63] || a > r + tol || a < r - tol) begin
                    nerr++;
                    $display("FAIL %s value: got %0d want %0.1f +- %0.1f",
                             tag, exp_result, r, tol);
                end
            end
        end
    endtask

    task automatic run_stream(input string tag);
        int n;
        n = stim.size();
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                in_valid = stim[i].v;
                s_x      = stim[i].d.x;
            end else begin
                in_valid = 1'b0;
                s_x      = $urandom();
            end
            @(posedge clk);
            #1;
            if (i >= 1 && i - 1 < n) begin
                if (stim[i-1].v)
                    check_out($sformatf("%s[%0d]", tag, i - 1), stim[i-1].d);
                else
                    chk($sformatf("%s[%0d] idle", tag, i - 1),
                        64'(out_valid), 64'd0);
            end
        end
        stim.delete();
    endtask

    initial begin
        cyc_t c;
        tbl[0]  = '{32'h0000_0000, 64'h0000_0000_0001_0000, 1'b1, 0};
        tbl[1]  = '{32'h0040_0000, 64'h0000_0000_0002_0000, 1'b1, 0};
        tbl[2]  = '{32'hFFC0_0000, 64'h0000_0000_0000_8000, 1'b1, 0};
        tbl[3]  = '{32'h0080_0000, 64'h0000_0000_0004_0000, 1'b1, 0};
        tbl[4]  = '{32'h0A00_0000, 64'h0100_0000_0000_0000, 1'b1, 0};
        tbl[5]  = '{32'd185136579, 64'd0, 1'b0, -1};
        tbl[6]  = '{32'h0BC0_0000, SAT, 1'b1, 0};
        tbl[7]  = '{32'h1900_0000, SAT, 1'b1, 0};
        tbl[8]  = '{32'hFC00_0000, 64'd1, 1'b1, 0};
        tbl[9]  = '{32'hFB00_0000, 64'd0, 1'b1, 0};
        tbl[10] = '{-32'sd161732362, 64'd0, 1'b1, -1};
        for (int j = 0; j < 8; j++)
            tbl[11+j] = '{32'((2*j + 1) * 262144), 64'd0, 1'b0, j};

        rst      = 1'b1;
        in_valid = 1'b0;
        s_x      = '0;
        #3;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset exp_result", exp_result, 64'd0);
        chk("reset segment_index", 64'(segment_index), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            c.v = 1'b1;
            c.d = tbl[i];
            stim.push_back(c);
        end
        run_stream("tbl");

        for (int i = 0; i < 160; i++) begin
            c.v     = ($urandom_range(0, 3) != 0);
            c.d.x   = 32'($urandom_range(0, 67 * 4194304 - 42)) - 32'(20 * 4194304);
            c.d.exp = '0;
            c.d.exact = 1'b0;
            c.d.seg = -1;
            stim.push_back(c);
        end
        run_stream("rnd");

        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            s_x      = 32'(i) << 22;
            @(posedge clk);
            #1;
        end
        chk("pre-reset out_valid", 64'(out_valid), 64'd1);
        chk("pre-reset value", exp_result, 64'h4_0000);
        #2;
        rst = 1'b1;
        #1;
        chk("mid-reset out_valid", 64'(out_valid), 64'd0);
        chk("mid-reset exp_result", exp_result, 64'd0);
        chk("mid-reset seg", 64'(segment_index), 64'd0);
        @(posedge clk);
        #1;
        chk("held-reset out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-reset stale %0d", i), 64'(out_valid), 64'd0);
        end
        c.v = 1'b1;
        c.d = tbl[1];
        stim.push_back(c);
        c.v = 1'b0;
        stim.push_back(c);
        run_stream("post");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
